// File: rtl/inv_tree_pulse_seq_pkg.sv
// rtl/inv_tree_pulse_seq_pkg.sv - shared types and defaults for the inverter-tree pulse sequencer
package inv_tree_seq_pkg;

  localparam int NUM_LEAF      = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_NP_W      = 8;
  localparam int DEF_DRAIN_CYC = 4;

  // One-hot encoding keeps each state decode a single flop.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    HIGH  = 5'b00010,
    LOW   = 5'b00100,
    DRAIN = 5'b01000,
    FIN   = 5'b10000
  } seq_state_t;

endpackage

// File: rtl/inv_tree_pulse_seq_if.sv
// rtl/inv_tree_pulse_seq_if.sv - control/status bundle between register side and the sequencer
interface inv_tree_pulse_seq_if #(
  parameter int CNT_W    = inv_tree_seq_pkg::DEF_CNT_W,
  parameter int NP_W     = inv_tree_seq_pkg::DEF_NP_W,
  parameter int NUM_LEAF = inv_tree_seq_pkg::NUM_LEAF
);

  logic                     start;
  logic [CNT_W-1:0]         pulse_width;
  logic [CNT_W-1:0]         gap_width;
  logic [NP_W-1:0]          num_pulses;
  logic                     busy;
  logic                     done;
  logic [NUM_LEAF*NP_W-1:0] leaf_cnt;
  logic                     mismatch;

  modport master (
    output start, pulse_width, gap_width, num_pulses,
    input  busy, done, leaf_cnt, mismatch
  );

  modport slave (
    input  start, pulse_width, gap_width, num_pulses,
    output busy, done, leaf_cnt, mismatch
  );

endinterface

// File: rtl/inv_tree_pulse_seq_leaf_mon.sv
// rtl/inv_tree_pulse_seq_leaf_mon.sv - per-leaf sync2, rising-edge detect and saturating counter
// Only built when INV_TREE_LEAF_MON_EN is defined.
`ifdef INV_TREE_LEAF_MON_EN
module inv_tree_leaf_mon #(
  parameter int NP_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_leaf,
  input  logic            i_clr,
  output logic [NP_W-1:0] o_cnt
);

  logic            r_s1;
  logic            r_s2;
  logic            r_prev;
  logic [NP_W-1:0] r_cnt;
  logic            w_rise;

  assign w_rise = r_s2 & ~r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_leaf;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      // Clear wins over a coincident edge so a new train starts from zero.
      if (i_clr) begin
        r_cnt <= '0;
      end else if (w_rise && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/inv_tree_pulse_seq.sv
// rtl/inv_tree_pulse_seq.sv - programmable pulse-train driver for the 4-leaf inverter tree
// Leaf edge counting and mismatch flag exist only when INV_TREE_LEAF_MON_EN is defined.
module inv_tree_pulse_seq
  import inv_tree_seq_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int NP_W      = DEF_NP_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  inv_tree_pulse_seq_if.slave   bus,
  input  logic [NUM_LEAF-1:0]   i_leaf_in,
  output logic                  o_din
);

  localparam logic [CNT_W-1:0] DRAIN_M1 = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [NP_W-1:0]  r_remain;
  logic [NP_W-1:0]  w_remain_nxt;
  logic [CNT_W-1:0] r_pw;
  logic [CNT_W-1:0] r_gw;
  logic [CNT_W-1:0] w_pw_in;
  logic [CNT_W-1:0] w_gw_in;
  logic             w_accept;
  logic             r_din;
  logic             r_busy;
  logic             r_done;

  assign w_pw_in = (bus.pulse_width == '0) ? ONE : bus.pulse_width;
  assign w_gw_in = (bus.gap_width   == '0) ? ONE : bus.gap_width;

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_remain_nxt = r_remain;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.num_pulses != '0) begin
            w_state_nxt  = HIGH;
            w_phase_nxt  = w_pw_in - 1'b1;
            w_remain_nxt = bus.num_pulses;
          end else begin
            w_state_nxt  = DRAIN;
            w_phase_nxt  = DRAIN_M1;
            w_remain_nxt = '0;
          end
        end
      end
      HIGH: begin
        if (r_phase == '0) begin
          w_state_nxt  = LOW;
          w_phase_nxt  = r_gw - 1'b1;
          w_remain_nxt = r_remain - 1'b1;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      LOW: begin
        if (r_phase == '0) begin
          if (r_remain != '0) begin
            w_state_nxt = HIGH;
            w_phase_nxt = r_pw - 1'b1;
          end else begin
            w_state_nxt = DRAIN;
            w_phase_nxt = DRAIN_M1;
          end
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      DRAIN: begin
        if (r_phase == '0) begin
          w_state_nxt = FIN;
        end else begin
          w_phase_nxt = r_phase - 1'b1;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so din/busy/done line up with the state flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_remain <= '0;
      r_pw     <= ONE;
      r_gw     <= ONE;
      r_din    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_remain <= w_remain_nxt;
      if (w_accept) begin
        r_pw <= w_pw_in;
        r_gw <= w_gw_in;
      end
      r_din  <= (w_state_nxt == HIGH);
      r_busy <= (w_state_nxt == HIGH) || (w_state_nxt == LOW) || (w_state_nxt == DRAIN);
      r_done <= (w_state_nxt == FIN);
    end
  end

  assign o_din    = r_din;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

`ifdef INV_TREE_LEAF_MON_EN
  logic [NP_W-1:0]          r_np;
  logic                     r_mismatch;
  logic                     w_bad;
  logic [NUM_LEAF*NP_W-1:0] w_leaf_cnt;

  for (genvar g = 0; g < NUM_LEAF; g++) begin : g_leaf
    inv_tree_leaf_mon #(
      .NP_W (NP_W)
    ) u_mon (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_leaf (i_leaf_in[g]),
      .i_clr  (w_accept),
      .o_cnt  (w_leaf_cnt[g*NP_W +: NP_W])
    );
  end

  // A saturated counter cannot prove the count, so it is reported as bad too.
  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < NUM_LEAF; k++) begin
      if ((w_leaf_cnt[k*NP_W +: NP_W] != r_np) || (&w_leaf_cnt[k*NP_W +: NP_W])) begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_np       <= '0;
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_np       <= bus.num_pulses;
      r_mismatch <= 1'b0;
    end else if (w_state_nxt == FIN) begin
      r_mismatch <= r_mismatch | w_bad;
    end
  end

  assign bus.leaf_cnt = w_leaf_cnt;
  assign bus.mismatch = r_mismatch;
`else
  logic w_unused_leaf;
  assign w_unused_leaf = ^i_leaf_in;
  assign bus.leaf_cnt  = '0;
  assign bus.mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_inv_tree_pulse_seq.sv
// tb/tb_inv_tree_pulse_seq.sv - directed and randomized trains against a waveform-level model
module tb_inv_tree_pulse_seq;
  import inv_tree_seq_pkg::*;

  localparam int DRAIN = DEF_DRAIN_CYC;
  localparam int NPW   = DEF_NP_W;
`ifdef INV_TREE_LEAF_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] leaf_in = 4'h0;
  logic       din;
  int         total = 0;
  int         bad = 0;

  inv_tree_pulse_seq_if bus ();

  inv_tree_pulse_seq dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .i_leaf_in (leaf_in),
    .o_din     (din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: din is N blocks of (pw ones, gw zeros), then DRAIN zeros, then the FIN cycle.
  task automatic run_train(input int pw, input int gw, input int n,
                           input logic [3:0] mask, input int poke);
    bit          q[$];
    int          pwe, gwe, len, c;
    logic [31:0] exp_cnt;
    logic        exp_mis;
    logic        dexp, prev;
    logic [2:0]  ew;
    pwe = (pw == 0) ? 1 : pw;
    gwe = (gw == 0) ? 1 : gw;
    for (int p = 0; p < n; p++) begin
      repeat (pwe) q.push_back(1'b1);
      repeat (gwe) q.push_back(1'b0);
    end
    repeat (DRAIN) q.push_back(1'b0);
    len = q.size() + 1;
    exp_cnt = '0;
    exp_mis = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = mask[k] ? ((n > 255) ? 255 : n) : 0;
      if (MON) begin
        exp_cnt[k*NPW +: NPW] = NPW'(c);
        if ((c != n) || (c == 255)) exp_mis = 1'b1;
      end
    end

    bus.start       = 1'b1;
    bus.pulse_width = 8'(pw);
    bus.gap_width   = 8'(gw);
    bus.num_pulses  = 8'(n);
    tick();
    bus.start       = 1'b0;
    bus.pulse_width = 8'($urandom);
    bus.gap_width   = 8'($urandom);
    bus.num_pulses  = 8'($urandom);
    prev = 1'b0;
    for (int t = 1; t <= len; t++) begin
      dexp    = (t <= q.size()) ? q[t-1] : 1'b0;
      leaf_in = mask & {4{prev}};
      if (t == poke) begin
        bus.start       = 1'b1;
        bus.pulse_width = 8'd9;
        bus.num_pulses  = 8'($urandom_range(1, 255));
      end
      @(negedge clk);
      ew = {dexp, (t < len), (t == len)};
      check($sformatf("wave pw=%0d gw=%0d n=%0d t=%0d", pw, gw, n, t),
            {61'd0, din, bus.busy, bus.done}, {61'd0, ew});
      if (t == 1) check("cleared_at_start", {31'd0, bus.mismatch, bus.leaf_cnt}, 64'd0);
      tick();
      bus.start = 1'b0;
      prev = dexp;
    end
    leaf_in = 4'h0;
    @(negedge clk);
    check($sformatf("idle_after n=%0d", n), {61'd0, din, bus.busy, bus.done}, 64'd0);
    check($sformatf("leaf_cnt n=%0d mask=%h", n, mask), {32'd0, bus.leaf_cnt}, {32'd0, exp_cnt});
    check($sformatf("mismatch n=%0d mask=%h", n, mask), {63'd0, bus.mismatch}, {63'd0, exp_mis});
    tick();
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.pulse_width = '0;
    bus.gap_width   = '0;
    bus.num_pulses  = '0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_state", {30'd0, din, bus.busy, bus.done, bus.mismatch, bus.leaf_cnt}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_train(3, 2, 4, 4'hF, 0);
    run_train(0, 0, 2, 4'hF, 0);
    run_train(5, 1, 0, 4'hF, 0);
    run_train(1, 1, 8, 4'h7, 0);
    repeat (3) begin
      @(negedge clk);
      check("mismatch_sticky", {63'd0, bus.mismatch}, {63'd0, MON});
      tick();
    end
    run_train(3, 2, 3, 4'hF, 3);
    run_train(2, 2, 2, 4'hF, 13);

    // Reset in the middle of a HIGH phase.
    bus.start = 1'b1; bus.pulse_width = 8'd5; bus.gap_width = 8'd3; bus.num_pulses = 8'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("pre_reset_high", {62'd0, din, bus.busy}, 64'd3);
    #2 rst = 1'b1;
    #1 check("async_reset", {62'd0, din, bus.busy}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_reset", {61'd0, din, bus.busy, bus.done}, 64'd0);
      tick();
    end
    run_train(5, 3, 3, 4'hF, 0);

    for (int i = 0; i < 8; i++) begin
      run_train($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 6),
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, 0);
    end
    run_train(0, 0, 255, 4'hF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
